// File: rtl/decode_issue_ctrl_pkg.sv
// Shared encodings and sizes for the decode/issue controller and its scoreboard.
package decode_issue_ctrl_pkg;
    localparam int PEND_W_DEF = 3;
    localparam int NUM_GPRS   = 32;
    localparam int GPR_NAME_W = $clog2(NUM_GPRS);

    typedef enum logic {
        DIC_RUN   = 1'b0,
        DIC_DRAIN = 1'b1
    } dic_state_e;
endpackage

// File: rtl/decode_issue_ctrl_if.sv
// Decode-to-issue handshake, bypass status, EX handshake and writeback retire bus.
interface decode_issue_ctrl_if;
    import decode_issue_ctrl_pkg::*;

    logic                  fd_valid, fd_ready;
    logic                  de_reads_a, de_reads_b, de_reads_c;
    logic [GPR_NAME_W-1:0] de_a_name, de_b_name, de_c_name;
    logic                  de_reads_xercr;
    logic                  de_writes_gpr0, de_writes_gpr1;
    logic [GPR_NAME_W-1:0] de_gpr0_name, de_gpr1_name;
    logic                  de_writes_xercr, de_serialise, de_flush;
    logic                  gpr_a_bypassed, gpr_b_bypassed, gpr_c_bypassed, xercr_bypassed;
    logic                  ex_ready, de_ex_valid;
    logic                  wb_gpr0_retire, wb_gpr1_retire;
    logic [GPR_NAME_W-1:0] wb_gpr0_reg, wb_gpr1_reg;
    logic                  wb_xercr_retire;
    logic                  sb_busy, sb_error;

    modport slave (
        input  fd_valid, de_reads_a, de_reads_b, de_reads_c, de_a_name, de_b_name, de_c_name,
               de_reads_xercr, de_writes_gpr0, de_writes_gpr1, de_gpr0_name, de_gpr1_name,
               de_writes_xercr, de_serialise, de_flush,
               gpr_a_bypassed, gpr_b_bypassed, gpr_c_bypassed, xercr_bypassed, ex_ready,
               wb_gpr0_retire, wb_gpr1_retire, wb_gpr0_reg, wb_gpr1_reg, wb_xercr_retire,
        output fd_ready, de_ex_valid, sb_busy, sb_error
    );

    modport master (
        output fd_valid, de_reads_a, de_reads_b, de_reads_c, de_a_name, de_b_name, de_c_name,
               de_reads_xercr, de_writes_gpr0, de_writes_gpr1, de_gpr0_name, de_gpr1_name,
               de_writes_xercr, de_serialise, de_flush,
               gpr_a_bypassed, gpr_b_bypassed, gpr_c_bypassed, xercr_bypassed, ex_ready,
               wb_gpr0_retire, wb_gpr1_retire, wb_gpr0_reg, wb_gpr1_reg, wb_xercr_retire,
        input  fd_ready, de_ex_valid, sb_busy, sb_error
    );
endinterface

// File: rtl/decode_issue_ctrl_scoreboard.sv
// Pending-writer counters: one per GPR plus XER/CR, saturating with a sticky error flag.
module decode_scoreboard
    import decode_issue_ctrl_pkg::*;
#(
    parameter int PEND_W = PEND_W_DEF,
    parameter int N_ENT  = NUM_GPRS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  inc0_en, inc1_en, dec0_en, dec1_en,
    input  logic [GPR_NAME_W-1:0] inc0_name, inc1_name, dec0_name, dec1_name,
    input  logic                  xer_inc, xer_dec,
    input  logic [GPR_NAME_W-1:0] rd_a_name, rd_b_name, rd_c_name,
    output logic                  rd_a_pend, rd_b_pend, rd_c_pend, xer_pend,
    output logic                  busy,
    output logic                  error
);
    localparam int                SUM_W = PEND_W + 2;
    localparam logic [SUM_W-1:0]  PMAX  = SUM_W'((1 << PEND_W) - 1);

    logic [N_ENT-1:0][PEND_W-1:0] pend, pend_nxt;
    logic [N_ENT-1:0]             ent_err;
    logic [PEND_W-1:0]            pend_xer;
    logic [PEND_W:0]              xer_nx;

    // Returns {error, next}; clamps to 0 on underflow and to max on overflow.
    function automatic logic [PEND_W:0] cnt_next(input logic [PEND_W-1:0] cur,
                                                 input logic [1:0] inc, input logic [1:0] dec);
        logic [SUM_W-1:0] sum;
        sum = SUM_W'(cur) + SUM_W'(inc);
        if (SUM_W'(dec) > sum) return {1'b1, {PEND_W{1'b0}}};
        sum = sum - SUM_W'(dec);
        if (sum > PMAX) return {1'b1, PMAX[PEND_W-1:0]};
        return {1'b0, sum[PEND_W-1:0]};
    endfunction

    for (genvar r = 0; r < N_ENT; r++) begin : g_ent
        logic [1:0]      inc, dec;
        logic [PEND_W:0] nx;
        assign inc = 2'(inc0_en && (inc0_name == GPR_NAME_W'(r)))
                   + 2'(inc1_en && (inc1_name == GPR_NAME_W'(r)));
        assign dec = 2'(dec0_en && (dec0_name == GPR_NAME_W'(r)))
                   + 2'(dec1_en && (dec1_name == GPR_NAME_W'(r)));
        assign nx          = cnt_next(pend[r], inc, dec);
        assign pend_nxt[r] = nx[PEND_W-1:0];
        assign ent_err[r]  = nx[PEND_W];
    end

    assign xer_nx = cnt_next(pend_xer, {1'b0, xer_inc}, {1'b0, xer_dec});

    always_ff @(posedge clk) begin
        if (reset) begin
            pend     <= '0;
            pend_xer <= '0;
            error    <= 1'b0;
        end else begin
            pend     <= pend_nxt;
            pend_xer <= xer_nx[PEND_W-1:0];
            if ((|ent_err) || xer_nx[PEND_W]) error <= 1'b1;
        end
    end

    assign rd_a_pend = pend[rd_a_name] != '0;
    assign rd_b_pend = pend[rd_b_name] != '0;
    assign rd_c_pend = pend[rd_c_name] != '0;
    assign xer_pend  = pend_xer != '0;
    assign busy      = (|pend) || xer_pend;
endmodule

// File: rtl/decode_issue_ctrl.sv
// Issue/stall/drain decision between decode and EX. Optional stall counters: DECODE_STALL_STATS_EN.
module decode_issue_ctrl
    import decode_issue_ctrl_pkg::*;
#(
    parameter int PEND_W = PEND_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    decode_issue_ctrl_if.slave io
`ifdef DECODE_STALL_STATS_EN
    ,
    output logic [31:0]        stat_hazard_cycles,
    output logic [31:0]        stat_drain_cycles
`endif
);
    dic_state_e state;
    logic       a_pend, b_pend, c_pend, xer_pend, sb_busy;
    logic       hazard, issue, ex_valid;

    decode_scoreboard #(.PEND_W(PEND_W), .N_ENT(NUM_GPRS)) u_sb (
        .clk       (clk),
        .reset     (reset),
        .inc0_en   (issue && io.de_writes_gpr0),
        .inc1_en   (issue && io.de_writes_gpr1),
        .dec0_en   (io.wb_gpr0_retire),
        .dec1_en   (io.wb_gpr1_retire),
        .inc0_name (io.de_gpr0_name),
        .inc1_name (io.de_gpr1_name),
        .dec0_name (io.wb_gpr0_reg),
        .dec1_name (io.wb_gpr1_reg),
        .xer_inc   (issue && io.de_writes_xercr),
        .xer_dec   (io.wb_xercr_retire),
        .rd_a_name (io.de_a_name),
        .rd_b_name (io.de_b_name),
        .rd_c_name (io.de_c_name),
        .rd_a_pend (a_pend),
        .rd_b_pend (b_pend),
        .rd_c_pend (c_pend),
        .xer_pend  (xer_pend),
        .busy      (sb_busy),
        .error     (io.sb_error)
    );

    // A pending writer only blocks an operand the bypass unit cannot forward.
    assign hazard = (io.de_reads_a     && a_pend   && !io.gpr_a_bypassed)
                 || (io.de_reads_b     && b_pend   && !io.gpr_b_bypassed)
                 || (io.de_reads_c     && c_pend   && !io.gpr_c_bypassed)
                 || (io.de_reads_xercr && xer_pend && !io.xercr_bypassed);

    assign ex_valid = !reset && io.fd_valid && (state == DIC_RUN) && !hazard && !io.de_flush
                   && !(io.de_serialise && sb_busy);
    assign issue          = ex_valid && io.ex_ready;
    assign io.de_ex_valid = ex_valid;
    assign io.fd_ready    = !reset && (issue || (io.fd_valid && io.de_flush));
    assign io.sb_busy     = sb_busy;

    // Flush drops the held instruction but leaves counters alone: its writers never issued.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= DIC_RUN;
        end else if (io.de_flush) begin
            state <= DIC_RUN;
        end else begin
            case (state)
                DIC_RUN:   if (io.fd_valid && io.de_serialise && sb_busy) state <= DIC_DRAIN;
                DIC_DRAIN: if (!sb_busy) state <= DIC_RUN;
                default:   state <= DIC_RUN;
            endcase
        end
    end

`ifdef DECODE_STALL_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_hazard_cycles <= '0;
            stat_drain_cycles  <= '0;
        end else begin
            if (io.fd_valid && (state == DIC_RUN) && hazard) stat_hazard_cycles <= stat_hazard_cycles + 32'd1;
            if (state == DIC_DRAIN) stat_drain_cycles <= stat_drain_cycles + 32'd1;
        end
    end
`else
    // Stall counters are not built in this configuration.
`endif
endmodule
